aluv_op_sequencer: RTL and testbench
====================================

Name: aluv_op_sequencer

Overview:
- Multicycle issue controller in front of the combinational vector ALU (6 lanes x 8 bit: add, sub, mul, div, FP-mul, pass-op1, pass-op2).
- Accepts one vector operation at a time over a valid/ready handshake and registers the ALU selector and operands.
- Holds them stable for an operation-dependent number of cycles, so the slow divider and FP-multiplier paths meet timing as multicycle paths.
- Captures the ALU result and presents it downstream over a second valid/ready handshake. Sits between the decode/register-read stage and writeback.

Parameters:
- DATA_WIDTH, 8, bits per lane
- LANES, 6, number of lanes
- SELECTOR_SIZE, 3, ALU selector width
- DEST_WIDTH, 4, destination vector-register tag width
- MUL_CYCLES, 2, execute cycles for selector 010 (must be >=1)
- DIV_CYCLES, 4, execute cycles for selector 011 (must be >=1)
- FPMUL_CYCLES, 3, execute cycles for selector 100 (must be >=1)
- CNT_WIDTH, 16, completed-operation counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous; aborts any in-flight or pending op
- inValid  in  1  op request valid
- inReady  out  1  sequencer can accept op
- inSelector  in  SELECTOR_SIZE  ALU op code
- inOperand1  in  LANES*DATA_WIDTH  packed lanes, lane 0 in LSBs
- inOperand2  in  LANES*DATA_WIDTH  packed lanes
- inDest  in  DEST_WIDTH  destination tag, carried with op
- aluSelector  out  SELECTOR_SIZE  registered selector to ALU
- aluOperand1  out  LANES*DATA_WIDTH  registered operand to ALU
- aluOperand2  out  LANES*DATA_WIDTH  registered operand to ALU
- aluResult  in  LANES*DATA_WIDTH  ALU combinational output
- outValid  out  1  result valid
- outReady  in  1  downstream accepts result
- outResult  out  LANES*DATA_WIDTH  captured result
- outDest  out  DEST_WIDTH  tag of outResult
- busy  out  1  state != IDLE
- opCount  out  CNT_WIDTH  completed (handed-off) ops, wraps

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, all outputs and registers 0 (aluSelector=000, operands 0, outValid=0, outResult=0, outDest=0, opCount=0). inReady=0 while rst=0.
- FSM states: IDLE, EXEC, DONE.
- inReady = !flush && (state==IDLE || (state==DONE && outReady)). This is combinational; no bubble on back-to-back ops.
- Accept (inValid && inReady):
  - Latch aluSelector, aluOperand1/2 and destination tag.
  - Load cnt = N-1. N = MUL_CYCLES for 010, DIV_CYCLES for 011, FPMUL_CYCLES for 100, else 1.
  - Go to EXEC.
- EXEC:
  - If cnt != 0: decrement.
  - If cnt == 0: capture aluResult into outResult and the tag into outDest, set outValid=1, go to DONE.
  - aluSelector/operands stay constant throughout EXEC and DONE.
- Latency: accept at edge t, outValid high after edge t+N. Minimum 1 cycle (add: valid the cycle after accept).
- DONE:
  - Hold outValid/outResult/outDest until outReady.
  - On handshake, opCount increments by 1 (wraps at 2^CNT_WIDTH).
  - Same-cycle accept of a new op goes directly to EXEC. Otherwise go to IDLE with outValid=0.
- IDLE: ALU-side registers keep last values. outResult keeps its last value but outValid=0.
- flush=1:
  - Next state IDLE, outValid=0, cnt=0.
  - No accept that cycle. A DONE result is discarded and opCount is not incremented, even if outReady=1.
  - Flush wins over every simultaneous event.
- Selector 101/110/111: treated as 1-cycle ops, same handshake.
- inValid without inReady: no state change; the requester must hold its inputs.
- Mid-operation async reset: immediate return to reset values; no partial result appears.

Test Plan:
- Single add: sel=000, op1 lanes=1..6, op2 lanes=10 each, accept at cycle 0, outReady=1 -> outValid in cycle 1, outResult lanes=11..16, opCount=1.
- Divide latency: sel=011, op1 lanes=100, op2 lanes=7 -> aluSelector=011 stable 4 cycles, outValid after 4th edge, lanes=14, busy high cycles 1-4.
- Back-to-back with stall: mul (2x3 per lane) then sub queued, outReady=0 for 3 cycles -> outResult=6 held, inReady=0. Release -> sub accepted the same cycle as the handoff, no idle cycle, opCount=2 after both.
- Flush during EXEC of FP-mul at cycle 2 -> outValid never asserts, state IDLE next cycle, opCount unchanged, new op accepted the following cycle.
- Flush in DONE with outReady=1 -> result dropped, opCount unchanged; the same cycle shows inReady=0.
- Async reset mid-divide (rst low between edges) -> outputs zero immediately; after release, inReady=1 and opCount=0.

Source files
------------

// File: rtl/aluv_op_sequencer.sv
// -----------------------------------------------------------------------------
// aluv_op_sequencer
//
// Multicycle issue controller placed in front of the combinational vector ALU.
// It accepts one vector operation at a time and registers the selector and
// operands. These stay stable for an op-dependent number of cycles, so the
// divider and FP-multiplier paths can be constrained as multicycle paths. The
// ALU result is then captured and handed downstream.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   flush             synchronous abort of any in-flight or pending op
//   inValid/inReady   op request handshake
//   inSelector        ALU op code
//   inOperand1/2      packed lanes, lane 0 in the LSBs
//   inDest            destination register tag, carried with the op
//   aluSelector       registered selector driven to the ALU
//   aluOperand1/2     registered operands driven to the ALU
//   aluResult         ALU combinational output
//   outValid/outReady result handshake
//   outResult         captured result
//   outDest           tag of outResult
//   busy              sequencer not idle
//   opCount           number of results handed off (wraps)
// -----------------------------------------------------------------------------
module aluv_op_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int LANES         = 6,
  parameter int SELECTOR_SIZE = 3,
  parameter int DEST_WIDTH    = 4,
  parameter int MUL_CYCLES    = 2,
  parameter int DIV_CYCLES    = 4,
  parameter int FPMUL_CYCLES  = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic [SELECTOR_SIZE-1:0]      inSelector,
  input  logic [LANES*DATA_WIDTH-1:0]   inOperand1,
  input  logic [LANES*DATA_WIDTH-1:0]   inOperand2,
  input  logic [DEST_WIDTH-1:0]         inDest,
  output logic [SELECTOR_SIZE-1:0]      aluSelector,
  output logic [LANES*DATA_WIDTH-1:0]   aluOperand1,
  output logic [LANES*DATA_WIDTH-1:0]   aluOperand2,
  input  logic [LANES*DATA_WIDTH-1:0]   aluResult,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [LANES*DATA_WIDTH-1:0]   outResult,
  output logic [DEST_WIDTH-1:0]         outDest,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          opCount
);

  localparam int LW     = LANES * DATA_WIDTH;
  localparam int MAX_A  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int MAX_N  = (MAX_A > FPMUL_CYCLES) ? MAX_A : FPMUL_CYCLES;
  // The execute counter only has to hold N-1 for the longest op.
  localparam int CW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DEST_WIDTH-1:0] dest_q;
  logic                  accept;
  logic                  handoff;
  logic                  capture;

  // Remaining execute cycles after the accept edge (N-1).
  function automatic logic [CW-1:0] exec_load(input logic [SELECTOR_SIZE-1:0] sel);
    logic [CW-1:0] n;
    n = '0;
    if (sel == SELECTOR_SIZE'(2))      n = CW'(MUL_CYCLES - 1);
    else if (sel == SELECTOR_SIZE'(3)) n = CW'(DIV_CYCLES - 1);
    else if (sel == SELECTOR_SIZE'(4)) n = CW'(FPMUL_CYCLES - 1);
    return n;
  endfunction

  // Ready is held low during reset, so nothing upstream can see a phantom
  // accept while the registers are being cleared.
  assign inReady = rst && !flush &&
                   ((state == IDLE) || ((state == DONE) && outReady));
  assign accept  = inValid && inReady;
  assign handoff = (state == DONE) && outReady && !flush;
  assign capture = (state == EXEC) && (cnt == '0) && !flush;

  assign outValid = (state == DONE);
  assign busy     = (state != IDLE);

  // NOTE: every variable gets its default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_n = EXEC;
            cnt_n   = exec_load(inSelector);
          end
        end
        EXEC: begin
          if (cnt != '0) cnt_n   = cnt - 1'b1;
          else           state_n = DONE;
        end
        DONE: begin
          if (accept) begin
            state_n = EXEC;
            cnt_n   = exec_load(inSelector);
          end else if (outReady) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // NOTE: the datapath registers are reset as well, so a mid-operation reset
  // leaves no stale operands or partial result visible on the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluSelector <= '0;
      aluOperand1 <= '0;
      aluOperand2 <= '0;
      dest_q      <= '0;
      outResult   <= '0;
      outDest     <= '0;
      opCount     <= '0;
    end else begin
      if (accept) begin
        aluSelector <= inSelector;
        aluOperand1 <= inOperand1;
        aluOperand2 <= inOperand2;
        dest_q      <= inDest;
      end
      if (capture) begin
        outResult <= aluResult;
        outDest   <= dest_q;
      end
      if (handoff) opCount <= opCount + 1'b1;
    end
  end

  // Only the lowest LW bits of the ALU result are meaningful; LW documents
  // the packed vector width used throughout.
  logic [LW-1:0] unused_width_ref;
  assign unused_width_ref = aluResult;

endmodule

// File: tb/tb_aluv_op_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for aluv_op_sequencer. A small per-lane ALU
// model closes the loop from aluSelector/aluOperand back to aluResult; all
// expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_aluv_op_sequencer;

  localparam int LW = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_selector = '0;
  logic [LW-1:0] in_operand1 = '0;
  logic [LW-1:0] in_operand2 = '0;
  logic [3:0]    in_dest = '0;
  logic [2:0]    alu_selector;
  logic [LW-1:0] alu_operand1;
  logic [LW-1:0] alu_operand2;
  logic [LW-1:0] alu_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] out_result;
  logic [3:0]    out_dest;
  logic          busy;
  logic [15:0]   op_count;

  int vectors     = 0;
  int miscompares = 0;

  aluv_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .inValid     (in_valid),
    .inReady     (in_ready),
    .inSelector  (in_selector),
    .inOperand1  (in_operand1),
    .inOperand2  (in_operand2),
    .inDest      (in_dest),
    .aluSelector (alu_selector),
    .aluOperand1 (alu_operand1),
    .aluOperand2 (alu_operand2),
    .aluResult   (alu_result),
    .outValid    (out_valid),
    .outReady    (out_ready),
    .outResult   (out_result),
    .outDest     (out_dest),
    .busy        (busy),
    .opCount     (op_count)
  );

  always #5 clk = ~clk;

  // Per-lane reference ALU; FP-mul is modelled as an integer multiply since
  // its value is never checked.
  always_comb begin
    alu_result = '0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a, b, r;
      a = alu_operand1[i*8 +: 8];
      b = alu_operand2[i*8 +: 8];
      case (alu_selector)
        3'b000:  r = a + b;
        3'b001:  r = a - b;
        3'b010:  r = a * b;
        3'b011:  r = (b == 0) ? 8'h00 : a / b;
        3'b100:  r = a * b;
        3'b101:  r = a;
        3'b110:  r = b;
        default: r = 8'h00;
      endcase
      alu_result[i*8 +: 8] = r;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] splat(input logic [7:0] v);
    return {6{v}};
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [LW-1:0] a,
                       input logic [LW-1:0] b, input logic [3:0] d);
    in_valid    = 1'b1;
    in_selector = sel;
    in_operand1 = a;
    in_operand2 = b;
    in_dest     = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_cnt;
    exp_cnt = 16'd0;

    // Reset state
    #12;
    check("rst_in_ready",  in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count",  op_count, 0);
    check("rst_alu_sel",   alu_selector, 0);
    check("rst_busy",      busy, 0);
    #6 rst = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);

    // Single add: lanes 1..6 + 10 -> 11..16, valid one cycle after accept
    out_ready = 1'b1;
    drive(3'b000, 48'h06_05_04_03_02_01, splat(8'd10), 4'd3);
    tick();
    in_valid = 1'b0;
    check("add_busy",      busy, 1);
    check("add_nvalid",    out_valid, 0);
    tick();
    check("add_valid",     out_valid, 1);
    check("add_result",    out_result, 48'h10_0F_0E_0D_0C_0B);
    check("add_dest",      out_dest, 3);
    tick();
    exp_cnt++;
    check("add_count",     op_count, exp_cnt);
    check("add_idle",      out_valid, 0);

    // Divide: 100/7 = 14, four execute cycles with a stable selector
    drive(3'b011, splat(8'd100), splat(8'd7), 4'd9);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("div_hold_sel", alu_selector, 3'b011);
      check("div_nvalid",   out_valid, 0);
      check("div_busy",     busy, 1);
      tick();
    end
    check("div_valid",     out_valid, 1);
    check("div_result",    out_result, splat(8'd14));
    check("div_dest",      out_dest, 9);
    tick();
    exp_cnt++;
    check("div_count",     op_count, exp_cnt);

    // Mul 2*3 then a queued sub 9-4 behind a 3-cycle downstream stall
    out_ready = 1'b0;
    drive(3'b010, splat(8'd2), splat(8'd3), 4'd1);
    tick();
    drive(3'b001, splat(8'd9), splat(8'd4), 4'd2);
    check("mul_exec_nready", in_ready, 0);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check("stall_valid",  out_valid, 1);
      check("stall_result", out_result, splat(8'd6));
      check("stall_nready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    check("b2b_count",     op_count, exp_cnt);
    check("b2b_sel",       alu_selector, 3'b001);
    check("b2b_busy",      busy, 1);
    tick();
    check("sub_result",    out_result, splat(8'd5));
    check("sub_dest",      out_dest, 2);
    tick();
    exp_cnt++;
    check("sub_count",     op_count, exp_cnt);

    // Flush in EXEC of FP-mul
    drive(3'b100, splat(8'd3), splat(8'd3), 4'd5);
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("flush_exec_nready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_exec_idle",   busy, 0);
    check("flush_exec_nvalid", out_valid, 0);
    check("flush_exec_count",  op_count, exp_cnt);
    tick();
    check("flush_exec_stay",   out_valid, 0);

    // New op accepted right after the flush, then flushed in DONE
    drive(3'b000, splat(8'd1), splat(8'd2), 4'd7);
    check("post_flush_ready",  in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    check("pf_result",         out_result, splat(8'd3));
    drive(3'b101, splat(8'd8), splat(8'd9), 4'd4);
    flush = 1'b1;
    #1;
    check("flush_done_nready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_done_nvalid", out_valid, 0);
    check("flush_done_count",  op_count, exp_cnt);
    check("flush_done_idle",   busy, 0);
    check("flush_done_noacc",  alu_selector, 3'b000);

    // Async reset in the middle of a divide
    drive(3'b011, splat(8'd50), splat(8'd5), 4'd6);
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    check("arst_busy",   busy, 0);
    check("arst_valid",  out_valid, 0);
    check("arst_sel",    alu_selector, 0);
    check("arst_op1",    alu_operand1, 0);
    check("arst_result", out_result, 0);
    check("arst_count",  op_count, 0);
    check("arst_ready",  in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_rel_ready", in_ready, 1);
    check("arst_rel_count", op_count, 0);
    tick();
    check("arst_no_partial", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
